// File: rtl/gate_exerciser.sv
// Drives the four {a,b} vectors into a gate block and checks its six results.
// Define GATE_EXERCISER_FAILLOG_EN to add fail_vec/fail_mask capture of the first failing sample.
module gate_exerciser #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] res_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] vec_idx
`ifdef GATE_EXERCISER_FAILLOG_EN
  ,
  output logic [1:0] fail_vec,
  output logic [5:0] fail_mask
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic [7:0] sweep;
  logic [5:0] expected;
  logic [5:0] diff;
  logic       mismatch;
  logic       last_sweep;
  logic [1:0] vec_next;

  assign expected   = {a_out & b_out, a_out | b_out, ~a_out, a_out ^ b_out,
                       ~(a_out & b_out), ~(a_out | b_out)};
  assign diff       = res_in ^ expected;
  assign mismatch   = |diff;
  assign last_sweep = (sweep == 8'(PASSES - 1));
  assign vec_next   = vec_idx + 2'd1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start && !abort) state_nxt = DRIVE;
      DRIVE: begin
        if (abort)                               state_nxt = IDLE;
        else if (settle_cnt == 4'(SETTLE - 1))   state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                               state_nxt = IDLE;
        else if (vec_idx != 2'd3 || !last_sweep) state_nxt = DRIVE;
        else                                     state_nxt = DONE;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: stimulus, counters and result registers follow the state transitions above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 4'd0;
      vec_idx    <= 2'd0;
      sweep      <= 8'd0;
      settle_cnt <= 4'd0;
`ifdef GATE_EXERCISER_FAILLOG_EN
      fail_vec   <= 2'd0;
      fail_mask  <= 6'd0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        pass  <= 1'b0;
        a_out <= 1'b0;
        b_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              vec_idx    <= 2'd0;
              sweep      <= 8'd0;
              err_count  <= 4'd0;
              pass       <= 1'b0;
              a_out      <= 1'b0;
              b_out      <= 1'b0;
              settle_cnt <= 4'd0;
`ifdef GATE_EXERCISER_FAILLOG_EN
              fail_vec   <= 2'd0;
              fail_mask  <= 6'd0;
`endif
            end
          end
          DRIVE: settle_cnt <= settle_cnt + 4'd1;
          SAMPLE: begin
            if (mismatch && err_count != 4'd15) err_count <= err_count + 4'd1;
`ifdef GATE_EXERCISER_FAILLOG_EN
            if (mismatch && err_count == 4'd0) begin
              fail_vec  <= vec_idx;
              fail_mask <= diff;
            end
`endif
            if (state_nxt == DRIVE) begin
              vec_idx    <= vec_next;
              a_out      <= vec_next[1];
              b_out      <= vec_next[0];
              settle_cnt <= 4'd0;
              if (vec_idx == 2'd3) sweep <= sweep + 8'd1;
            end else begin
              a_out <= 1'b0;
              b_out <= 1'b0;
            end
          end
          DONE: begin
            done <= 1'b1;
            pass <= (err_count == 4'd0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Self-checking bench for gate_exerciser: a spec-level cycle model plus directed runs.
// Instance u0 uses PASSES=1, u1 uses PASSES=5; both use SETTLE=2.
module tb_gate_exerciser;

  localparam int S  = 2;
  localparam int P0 = 1;
  localparam int P1 = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_v;
  logic [1:0] abort_v;
  logic [5:0] res_v [2];
  wire  [1:0] a_v, b_v, busy_v, done_v, pass_v;
  wire  [3:0] err_v [2];
  wire  [1:0] vec_v [2];
`ifdef GATE_EXERCISER_FAILLOG_EN
  wire  [1:0] fv_v [2];
  wire  [5:0] fm_v [2];
`endif

  int tests = 0;
  int failed = 0;
  int k [2];
  bit track [2];
  int mode [2];

  always #5 clk = ~clk;

  gate_exerciser #(.SETTLE(S), .PASSES(P0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .res_in(res_v[0]),
    .a_out(a_v[0]), .b_out(b_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .vec_idx(vec_v[0])
`ifdef GATE_EXERCISER_FAILLOG_EN
    , .fail_vec(fv_v[0]), .fail_mask(fm_v[0])
`endif
  );

  gate_exerciser #(.SETTLE(S), .PASSES(P1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .res_in(res_v[1]),
    .a_out(a_v[1]), .b_out(b_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .vec_idx(vec_v[1])
`ifdef GATE_EXERCISER_FAILLOG_EN
    , .fail_vec(fv_v[1]), .fail_mask(fm_v[1])
`endif
  );

  // Gate block under test: mode 0 correct, 1 = c stuck at 1, 2 = every output inverted.
  function automatic logic [5:0] gate_model(input logic a, input logic b, input int m);
    logic [5:0] g;
    g = {a & b, a | b, ~a, a ^ b, ~(a & b), ~(a | b)};
    if (m == 1) g = g | 6'b100000;
    else if (m == 2) g = ~g;
    return g;
  endfunction

  always_comb begin
    res_v[0] = gate_model(a_v[0], b_v[0], mode[0]);
    res_v[1] = gate_model(a_v[1], b_v[1], mode[1]);
  end

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observation k counts edges since the start edge: vector k/(S+1), err counts completed samples.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (track[i]) begin
        int p, t, n, e, v;
        p = (i == 0) ? P0 : P1;
        t = 4 * p * (S + 1);
        n = k[i] / (S + 1);
        e = (mode[i] == 0) ? 0 : (mode[i] == 1) ? n - n / 4 : n;
        if (e > 15) e = 15;
        if (k[i] < t) begin
          v = n % 4;
          check_output($sformatf("u%0d k%0d busy", i, k[i]), busy_v[i], 1);
          check_output($sformatf("u%0d k%0d done", i, k[i]), done_v[i], 0);
          check_output($sformatf("u%0d k%0d pass", i, k[i]), pass_v[i], 0);
          check_output($sformatf("u%0d k%0d vec", i, k[i]), vec_v[i], v);
          check_output($sformatf("u%0d k%0d a", i, k[i]), a_v[i], v / 2);
          check_output($sformatf("u%0d k%0d b", i, k[i]), b_v[i], v % 2);
          check_output($sformatf("u%0d k%0d err", i, k[i]), err_v[i], e);
        end else if (k[i] == t) begin
          check_output($sformatf("u%0d k%0d busy", i, k[i]), busy_v[i], 1);
          check_output($sformatf("u%0d k%0d done", i, k[i]), done_v[i], 0);
          check_output($sformatf("u%0d k%0d ab", i, k[i]), {a_v[i], b_v[i]}, 0);
          check_output($sformatf("u%0d k%0d err", i, k[i]), err_v[i], e);
        end else begin
          check_output($sformatf("u%0d end done", i), done_v[i], 1);
          check_output($sformatf("u%0d end busy", i), busy_v[i], 0);
          check_output($sformatf("u%0d end pass", i), pass_v[i], (e == 0) ? 1 : 0);
          check_output($sformatf("u%0d end err", i), err_v[i], e);
          check_output($sformatf("u%0d end vec", i), vec_v[i], 3);
          track[i] = 0;
        end
        k[i]++;
      end
    end
  end

  task automatic check_idle_zero(input int i, input string tag);
    check_output({tag, " busy"}, busy_v[i], 0);
    check_output({tag, " done"}, done_v[i], 0);
    check_output({tag, " pass"}, pass_v[i], 0);
    check_output({tag, " err"}, err_v[i], 0);
    check_output({tag, " vec"}, vec_v[i], 0);
    check_output({tag, " ab"}, {a_v[i], b_v[i]}, 0);
  endtask

  task automatic begin_run(input int i, input int m);
    mode[i] = m;
    @(negedge clk); #1;
    start_v[i] = 1'b1;
    k[i] = 0;
    track[i] = 1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
  endtask

  task automatic wait_obs(input int i, input int target);
    int guard = 0;
    while (k[i] < target && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 300) check_output("wait_obs timeout", 1, 0);
  endtask

  task automatic run_test(input int i, input int m, input int exp_lat,
                          input int exp_pass, input int exp_err);
    int cyc = 0;
    begin_run(i, m);
    while (!done_v[i] && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_output($sformatf("u%0d mode%0d latency", i, m), cyc, exp_lat);
    check_output($sformatf("u%0d mode%0d pass", i, m), pass_v[i], exp_pass);
    check_output($sformatf("u%0d mode%0d err", i, m), err_v[i], exp_err);
    @(negedge clk); #1;
    track[i] = 0;
  endtask

  initial begin
    start_v = 2'b00;
    abort_v = 2'b00;
    mode[0] = 0; mode[1] = 0;
    track[0] = 0; track[1] = 0;
    k[0] = 0; k[1] = 0;
    rst = 1'b1;
    #3;
    check_idle_zero(0, "reset u0");
    check_idle_zero(1, "reset u1");
    @(negedge clk); #1;
    rst = 1'b0;

    run_test(0, 0, 13, 1, 0);
    repeat (3) @(negedge clk);
    check_output("idle hold pass", pass_v[0], 1);

    run_test(0, 1, 13, 0, 3);
`ifdef GATE_EXERCISER_FAILLOG_EN
    check_output("faillog vec", fv_v[0], 0);
    check_output("faillog mask", fm_v[0], 32);
`endif
    repeat (4) @(negedge clk);
    check_output("idle hold err", err_v[0], 3);

    @(negedge clk); #1;
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check_output("start+abort busy", busy_v[0], 0);
    check_output("start+abort err kept", err_v[0], 3);

    run_test(1, 2, 61, 0, 15);

    begin_run(0, 1);
    @(negedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_obs(0, S + 2);
    abort_v[0] = 1'b1;
    track[0] = 0;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    check_output("abort busy", busy_v[0], 0);
    check_output("abort ab", {a_v[0], b_v[0]}, 0);
    check_output("abort done", done_v[0], 0);
    check_output("abort pass", pass_v[0], 0);
    check_output("abort err held", err_v[0], 1);
    @(posedge clk); #1;
    check_output("abort no late done", done_v[0], 0);

    begin_run(0, 1);
    wait_obs(0, 2 * S + 2);
    track[0] = 0;
    rst = 1'b1;
    #1;
    check_idle_zero(0, "async reset");
`ifdef GATE_EXERCISER_FAILLOG_EN
    check_output("async reset fail_mask", fm_v[0], 0);
`endif
    @(negedge clk); #1;
    rst = 1'b0;
    run_test(0, 0, 13, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
